// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_wb_scheduler_pkg: shared register-file widths, writeback source indices and request record.
package regfile_wb_scheduler_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_NREGS = 32;
  localparam int REG_ADDR_W = 5;
  localparam int RF_NREQ = 3;
  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_MULDIV = 2;
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [RF_XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter; the pointer names the highest-priority requester.
module rr_arbiter #(
  parameter int N = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);
  logic [PW-1:0] k;
  always_comb begin
    gnt_idx = ptr;
    k = ptr;
    // Walk from the farthest offset back to ptr so the nearest requester is the last to win.
    for (int i = N - 1; i >= 0; i--) begin
      k = PW'((int'(ptr) + i) % N);
      if (req[k]) gnt_idx = k;
    end
    gnt = (|req) ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: round-robin register-file write port sharing plus busy-bit scoreboard for issue hazards.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int XLEN = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int AW = $clog2(NREGS),
  parameter int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           issue_valid,
  input  logic                           issue_we,
  input  logic [AW-1:0]                  issue_rd,
  input  logic [AW-1:0]                  issue_rs1,
  input  logic [AW-1:0]                  issue_rs2,
  output logic                           issue_ready,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ-1:0][AW-1:0]        req_addr,
  input  logic [NREQ-1:0][XLEN-1:0]      req_data,
  output logic [NREQ-1:0]                req_ready,
  output logic                           w_enabled,
  output logic [AW-1:0]                  w_addr,
  output logic [XLEN-1:0]                w_data,
  output logic [NREGS-1:0]               busy_mask
);
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [NREGS-1:0] busy_q, busy_d, clr, set, eff_busy;
  logic [NREQ-1:0] req_eff, gnt;
  logic grant;
  always_comb req_eff = rstn ? req_valid : '0;
  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req(req_eff),
    .ptr(rr_ptr_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  always_comb begin
    grant = |gnt;
    req_ready = gnt;
    w_addr = req_addr[gnt_idx];
    w_data = req_data[gnt_idx];
    w_enabled = grant & (w_addr != '0);
    clr = grant ? NREGS'(1) << w_addr : '0;
    // The register file forwards this cycle's write, so its target no longer blocks issue.
    eff_busy = busy_q & ~clr;
    issue_ready = rstn & ~eff_busy[issue_rs1] & ~eff_busy[issue_rs2] & ~(issue_we & eff_busy[issue_rd]);
    set = (issue_valid & issue_ready & issue_we & (issue_rd != '0)) ? NREGS'(1) << issue_rd : '0;
    busy_d = rstn ? (eff_busy | set) : '0;
    rr_ptr_d = !rstn ? '0 : !grant ? rr_ptr_q : (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
  end
  always_ff @(posedge clk) begin
    busy_q <= busy_d;
    rr_ptr_q <= rr_ptr_d;
  end
  always_comb busy_mask = busy_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed vector table for the scheduler corner cases, then randomized traffic against a scoreboard model.
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic issue_valid, issue_we, issue_ready;
  logic [4:0] issue_rd, issue_rs1, issue_rs2;
  logic [2:0] req_valid, req_ready;
  logic [2:0][4:0] req_addr;
  logic [2:0][31:0] req_data;
  logic w_enabled;
  logic [4:0] w_addr;
  logic [31:0] w_data, busy_mask;
  int nvec = 0;
  int nerr = 0;

  regfile_wb_scheduler dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_ready(issue_ready),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .w_enabled(w_enabled), .w_addr(w_addr), .w_data(w_data), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r_n, iv, we;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] rv;
    logic [4:0] a0, a1, a2;
    logic e_rdy;
    logic [2:0] e_gnt;
    logic e_wen;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tv[24];

  function automatic vec_t mk(logic r_n, logic iv, logic we, int rd, int rs1, int rs2, logic [2:0] rv,
                              int a0, int a1, int a2, logic e_rdy, logic [2:0] e_gnt, logic e_wen, logic [31:0] e_busy);
    vec_t v;
    v.r_n = r_n; v.iv = iv; v.we = we;
    v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.rv = rv; v.a0 = 5'(a0); v.a1 = 5'(a1); v.a2 = 5'(a2);
    v.e_rdy = e_rdy; v.e_gnt = e_gnt; v.e_wen = e_wen; v.e_busy = e_busy;
    return v;
  endfunction

  function automatic logic [31:0] dat(int s, int a);
    return 32'hD000_0000 | 32'(s << 8) | 32'(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  wb_req_t pr[3];
  logic [31:0] m_busy;
  int m_ptr;

  function automatic logic eb(logic [31:0] busy, int r, int win, int wa);
    return r != 0 && busy[r] && !(win >= 0 && wa == r);
  endfunction

  initial begin
    int gi, win, wa;
    logic exp_rdy;
    issue_valid = 0; issue_we = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    req_valid = 0; req_addr = '0; req_data = '0;
    // reset, then idle with arbitrary operands
    tv[0]  = mk(0, 0,0, 0,0,0, 3'b111, 1,2,3, 0, 3'b000, 0, 32'h0);
    tv[1]  = mk(1, 0,1, 31,3,9, 3'b000, 0,0,0, 1, 3'b000, 0, 32'h0);
    // RAW on x5 until the LSU writeback, which is forwarded in the grant cycle
    tv[2]  = mk(1, 1,1, 5,1,2, 3'b000, 0,0,0, 1, 3'b000, 0, 32'h20);
    tv[3]  = mk(1, 1,0, 6,5,0, 3'b000, 0,0,0, 0, 3'b000, 0, 32'h20);
    tv[4]  = mk(1, 1,0, 6,5,0, 3'b000, 0,0,0, 0, 3'b000, 0, 32'h20);
    tv[5]  = mk(1, 1,0, 6,5,0, 3'b010, 0,5,0, 1, 3'b010, 1, 32'h0);
    // rotation with all sources requesting from pointer 0
    tv[6]  = mk(0, 0,0, 0,0,0, 3'b000, 0,0,0, 0, 3'b000, 0, 32'h0);
    tv[7]  = mk(1, 0,0, 0,0,0, 3'b111, 1,2,3, 1, 3'b001, 1, 32'h0);
    tv[8]  = mk(1, 0,0, 0,0,0, 3'b111, 1,2,3, 1, 3'b010, 1, 32'h0);
    tv[9]  = mk(1, 0,0, 0,0,0, 3'b111, 1,2,3, 1, 3'b100, 1, 32'h0);
    tv[10] = mk(1, 0,0, 0,0,0, 3'b111, 1,2,3, 1, 3'b001, 1, 32'h0);
    tv[11] = mk(1, 0,0, 0,0,0, 3'b111, 1,2,3, 1, 3'b010, 1, 32'h0);
    tv[12] = mk(1, 0,0, 0,0,0, 3'b111, 1,2,3, 1, 3'b100, 1, 32'h0);
    // same-cycle set and clear of x7, then MULDIV clears it
    tv[13] = mk(1, 1,1, 7,0,0, 3'b001, 7,0,0, 1, 3'b001, 1, 32'h80);
    tv[14] = mk(1, 0,0, 0,0,0, 3'b100, 0,0,7, 1, 3'b100, 1, 32'h0);
    // x0 destination on both sides
    tv[15] = mk(1, 1,1, 0,0,0, 3'b001, 0,0,0, 1, 3'b001, 0, 32'h0);
    // build busy 0xF0, check rs2 RAW and WAW stalls
    tv[16] = mk(1, 1,1, 4,0,0, 3'b000, 0,0,0, 1, 3'b000, 0, 32'h10);
    tv[17] = mk(1, 1,1, 5,0,0, 3'b000, 0,0,0, 1, 3'b000, 0, 32'h30);
    tv[18] = mk(1, 1,1, 6,0,0, 3'b000, 0,0,0, 1, 3'b000, 0, 32'h70);
    tv[19] = mk(1, 1,1, 7,0,0, 3'b000, 0,0,0, 1, 3'b000, 0, 32'hF0);
    tv[20] = mk(1, 1,0, 0,0,4, 3'b000, 0,0,0, 0, 3'b000, 0, 32'hF0);
    tv[21] = mk(1, 1,1, 6,0,0, 3'b000, 0,0,0, 0, 3'b000, 0, 32'hF0);
    // reset with a pending LSU request, granted right after
    tv[22] = mk(0, 0,0, 0,0,0, 3'b010, 0,9,0, 0, 3'b000, 0, 32'h0);
    tv[23] = mk(1, 0,0, 0,0,0, 3'b010, 0,9,0, 1, 3'b010, 1, 32'h0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rstn = tv[i].r_n; issue_valid = tv[i].iv; issue_we = tv[i].we;
      issue_rd = tv[i].rd; issue_rs1 = tv[i].rs1; issue_rs2 = tv[i].rs2;
      req_valid = tv[i].rv;
      req_addr[0] = tv[i].a0; req_addr[1] = tv[i].a1; req_addr[2] = tv[i].a2;
      for (int s = 0; s < 3; s++) req_data[s] = dat(s, int'(req_addr[s]));
      #1;
      chk($sformatf("t%0d issue_ready", i), 32'(issue_ready), 32'(tv[i].e_rdy));
      chk($sformatf("t%0d req_ready", i), 32'(req_ready), 32'(tv[i].e_gnt));
      chk($sformatf("t%0d w_enabled", i), 32'(w_enabled), 32'(tv[i].e_wen));
      if (tv[i].e_gnt != 3'b000) begin
        gi = tv[i].e_gnt[0] ? 0 : tv[i].e_gnt[1] ? 1 : 2;
        chk($sformatf("t%0d w_addr", i), 32'(w_addr), 32'(req_addr[gi]));
        chk($sformatf("t%0d w_data", i), w_data, dat(gi, int'(req_addr[gi])));
      end
      @(posedge clk);
      #1;
      chk($sformatf("t%0d busy_mask", i), busy_mask, tv[i].e_busy);
    end
    // randomized traffic; requesters hold each request until the model says it was granted
    m_busy = '0; m_ptr = 0;
    for (int s = 0; s < 3; s++) pr[s] = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rstn = (c != 0) && ($urandom_range(0, 40) != 0);
      issue_valid = 1'($urandom_range(0, 1));
      issue_we = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 7));
      issue_rs1 = 5'($urandom_range(0, 7));
      issue_rs2 = 5'($urandom_range(0, 7));
      for (int s = 0; s < 3; s++) begin
        if (!pr[s].valid && $urandom_range(0, 2) == 0) begin
          pr[s].valid = 1'b1;
          pr[s].addr = 5'($urandom_range(0, 7));
          pr[s].data = $urandom;
        end
        req_valid[s] = pr[s].valid; req_addr[s] = pr[s].addr; req_data[s] = pr[s].data;
      end
      win = -1;
      if (rstn)
        for (int k = 0; k < 3; k++)
          if (win < 0 && pr[(m_ptr + k) % 3].valid) win = (m_ptr + k) % 3;
      wa = (win >= 0) ? int'(pr[win].addr) : 0;
      exp_rdy = rstn && !eb(m_busy, int'(issue_rs1), win, wa) && !eb(m_busy, int'(issue_rs2), win, wa)
                && !(issue_we && eb(m_busy, int'(issue_rd), win, wa));
      #1;
      chk($sformatf("r%0d issue_ready", c), 32'(issue_ready), 32'(exp_rdy));
      chk($sformatf("r%0d req_ready", c), 32'(req_ready), (win >= 0) ? 32'(1 << win) : 32'h0);
      chk($sformatf("r%0d w_enabled", c), 32'(w_enabled), 32'(win >= 0 && wa != 0));
      if (win >= 0) begin
        chk($sformatf("r%0d w_addr", c), 32'(w_addr), 32'(wa));
        chk($sformatf("r%0d w_data", c), w_data, pr[win].data);
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
        m_busy = '0; m_ptr = 0;
      end else begin
        if (win >= 0) begin
          m_busy[wa] = 1'b0;
          m_ptr = (win + 1) % 3;
          pr[win].valid = 1'b0;
        end
        if (issue_valid && exp_rdy && issue_we && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
      chk($sformatf("r%0d busy_mask", c), busy_mask, m_busy);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
